dmem_unit: RTL and testbench

Parametrised data-memory stage for the Y86-64 pipeline. It replaces the fixed 256-word, zero-wait memory stage with a configurable-depth word array, programmable access latency, and a valid/ready handshake on both sides. It reports Y86 status codes (AOK/HLT/ADR/INS) and has a side debug read port. It sits between the execute and write-back pipeline registers.

---
 rtl/y86_pkg.sv | 43 ++++
 rtl/dmem_unit_if.sv | 25 ++
 rtl/dmem_array.sv | 27 ++
 rtl/dmem_unit.sv | 138 +++++++++++++
 tb/tb_dmem_unit.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 constants, FSM state type and icode decode helpers for the memory stage.
package y86_pkg;

   localparam logic [3:0] I_HALT   = 4'h0;
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_RRMOVQ = 4'h2;
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;

   localparam logic [2:0] S_AOK = 3'd1;
   localparam logic [2:0] S_HLT = 3'd2;
   localparam logic [2:0] S_ADR = 3'd3;
   localparam logic [2:0] S_INS = 4'd4;

   typedef enum logic [1:0] {StIdle, StAccess, StResp} dmem_state_e;

   function automatic logic is_mem_op(input logic [3:0] icode);
      case (icode)
         I_RMMOVQ, I_MRMOVQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: return 1'b1;
         default:                                           return 1'b0;
      endcase
   endfunction

   function automatic logic is_write_op(input logic [3:0] icode);
      case (icode)
         I_RMMOVQ, I_CALL, I_PUSHQ: return 1'b1;
         default:                   return 1'b0;
      endcase
   endfunction

   // ret and popq address through the old stack pointer in valA.
   function automatic logic uses_vala_addr(input logic [3:0] icode);
      return (icode == I_RET) || (icode == I_POPQ);
   endfunction

endpackage

// File: rtl/dmem_unit_if.sv
// Request/response handshake bundle between execute, memory and write-back stages.
interface dmem_unit_if #(
   parameter int unsigned DATA_W = 64
);
   logic              req_valid;
   logic              req_ready;
   logic [3:0]        icode;
   logic [63:0]       valA;
   logic [63:0]       valE;
   logic [63:0]       valP;
   logic              resp_valid;
   logic              resp_ready;
   logic [DATA_W-1:0] valM;
   logic [2:0]        stat;

   modport master (
      output req_valid, icode, valA, valE, valP, resp_ready,
      input  req_ready, resp_valid, valM, stat
   );

   modport slave (
      input  req_valid, icode, valA, valE, valP, resp_ready,
      output req_ready, resp_valid, valM, stat
   );
endinterface

// File: rtl/dmem_array.sv
// Word storage: synchronous write, registered synchronous read, combinational debug read.
module dmem_array #(
   parameter int unsigned DATA_W = 64,
   parameter int unsigned DEPTH  = 256
) (
   input  logic                     clk_i,
   input  logic                     we_i,
   input  logic [$clog2(DEPTH)-1:0] waddr_i,
   input  logic [DATA_W-1:0]        wdata_i,
   input  logic                     re_i,
   input  logic [$clog2(DEPTH)-1:0] raddr_i,
   output logic [DATA_W-1:0]        rdata_o,
   input  logic [$clog2(DEPTH)-1:0] dbg_addr_i,
   output logic [DATA_W-1:0]        dbg_data_o
);
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   // Contents are intentionally not reset.
   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      if (re_i) rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o    = rdata_q;
   assign dbg_data_o = mem_q[dbg_addr_i];
endmodule

// File: rtl/dmem_unit.sv
// Y86-64 data-memory stage: handshake FSM, wait counter, address check, status reporting.
module dmem_unit
   import y86_pkg::*;
#(
   parameter int unsigned DATA_W   = 64,
   parameter int unsigned DEPTH    = 256,
   parameter int unsigned WAIT_CYC = 0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   dmem_unit_if.slave               bus,
   input  logic [$clog2(DEPTH)-1:0] dbg_addr,
   output logic [DATA_W-1:0]        dbg_data
);
   localparam int unsigned AW       = $clog2(DEPTH);
   localparam logic [3:0]  WaitInit = (WAIT_CYC == 0) ? 4'd0 : 4'(WAIT_CYC - 1);

   dmem_state_e       state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [2:0]        stat_q, stat_d;
   logic              rd_sel_q, rd_sel_d;
   logic [3:0]        icode_q;
   logic [63:0]       vala_q, vale_q, valp_q;

   logic              accept, addr_ok, mem_op, commit, arr_we, arr_re;
   logic [3:0]        cur_icode;
   logic [63:0]       cur_vala, cur_vale, cur_valp, cur_addr;
   logic [DATA_W-1:0] arr_wdata, arr_rdata;

   // Decode the live request while idle, the latched one afterwards.
   always_comb begin
      accept = (state_q == StIdle) && bus.req_valid;
      if (state_q == StIdle) begin
         cur_icode = bus.icode;
         cur_vala  = bus.valA;
         cur_vale  = bus.valE;
         cur_valp  = bus.valP;
      end else begin
         cur_icode = icode_q;
         cur_vala  = vala_q;
         cur_vale  = vale_q;
         cur_valp  = valp_q;
      end
      cur_addr  = uses_vala_addr(cur_icode) ? cur_vala : cur_vale;
      addr_ok   = (cur_addr[63:AW] == '0);
      mem_op    = is_mem_op(cur_icode);
      // With no wait states the array operation happens on the accept edge itself.
      commit    = mem_op && addr_ok &&
                  ((WAIT_CYC == 0) ? accept : ((state_q == StAccess) && (cnt_q == 4'd0)));
      arr_we    = commit && is_write_op(cur_icode);
      arr_re    = commit && !is_write_op(cur_icode);
      arr_wdata = DATA_W'((cur_icode == I_CALL) ? cur_valp : cur_vala);
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= StIdle;
      else        state_q <= state_d;
   end

   // FSM next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: begin
            if (accept) begin
               state_d = (mem_op && addr_ok && (WAIT_CYC != 0)) ? StAccess : StResp;
            end
         end
         StAccess: if (cnt_q == 4'd0) state_d = StResp;
         StResp:   if (bus.resp_ready) state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // FSM outputs; valM is forced to zero unless this response carries read data.
   always_comb begin
      bus.req_ready  = (state_q == StIdle);
      bus.resp_valid = (state_q == StResp);
      bus.valM       = rd_sel_q ? arr_rdata : '0;
      bus.stat       = stat_q;
   end

   // Wait counter, status and read-select next state.
   always_comb begin
      cnt_d    = cnt_q;
      stat_d   = stat_q;
      rd_sel_d = rd_sel_q | arr_re;
      if (accept) begin
         cnt_d    = WaitInit;
         rd_sel_d = arr_re;
         if (cur_icode == I_HALT)     stat_d = S_HLT;
         else if (cur_icode >= 4'hC)  stat_d = S_INS;
         else if (mem_op && !addr_ok) stat_d = S_ADR;
         else                         stat_d = S_AOK;
      end else if ((state_q == StAccess) && (cnt_q != 4'd0)) begin
         cnt_d = cnt_q - 4'd1;
      end
   end

   // Request latch and response registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= 4'd0;
         stat_q   <= S_AOK;
         rd_sel_q <= 1'b0;
         icode_q  <= 4'd0;
         vala_q   <= '0;
         vale_q   <= '0;
         valp_q   <= '0;
      end else begin
         cnt_q    <= cnt_d;
         stat_q   <= stat_d;
         rd_sel_q <= rd_sel_d;
         if (accept) begin
            icode_q <= bus.icode;
            vala_q  <= bus.valA;
            vale_q  <= bus.valE;
            valp_q  <= bus.valP;
         end
      end
   end

   dmem_array #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_array (
      .clk_i      (clk),
      .we_i       (arr_we),
      .waddr_i    (cur_addr[AW-1:0]),
      .wdata_i    (arr_wdata),
      .re_i       (arr_re),
      .raddr_i    (cur_addr[AW-1:0]),
      .rdata_o    (arr_rdata),
      .dbg_addr_i (dbg_addr),
      .dbg_data_o (dbg_data)
   );
endmodule

// File: tb/tb_dmem_unit.sv
// Self-checking bench: three memory stages (WAIT_CYC 0, 3, 4) against a word-level reference model.
module tb_dmem_unit;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, resp_ready;
   logic [3:0]  icode;
   logic [63:0] valA, valE, valP;
   logic [7:0]  dbg_addr;
   int          sel;

   logic        req_ready, resp_valid;
   logic [63:0] valM, dbg_data, dbg0, dbg1, dbg2;
   logic [2:0]  stat;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [63:0] mdl [int];  // key = dut*1024 + word index; absent = never written

   always #5 clk = ~clk;

   dmem_unit_if #(.DATA_W(64)) if0 ();
   dmem_unit_if #(.DATA_W(64)) if1 ();
   dmem_unit_if #(.DATA_W(64)) if2 ();

   assign if0.req_valid = req_valid && (sel == 0);
   assign if1.req_valid = req_valid && (sel == 1);
   assign if2.req_valid = req_valid && (sel == 2);
   assign if0.resp_ready = resp_ready;
   assign if1.resp_ready = resp_ready;
   assign if2.resp_ready = resp_ready;
   assign if0.icode = icode;
   assign if1.icode = icode;
   assign if2.icode = icode;
   assign if0.valA = valA;
   assign if1.valA = valA;
   assign if2.valA = valA;
   assign if0.valE = valE;
   assign if1.valE = valE;
   assign if2.valE = valE;
   assign if0.valP = valP;
   assign if1.valP = valP;
   assign if2.valP = valP;

   dmem_unit #(.DATA_W(64), .DEPTH(256), .WAIT_CYC(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .bus(if0), .dbg_addr(dbg_addr), .dbg_data(dbg0));
   dmem_unit #(.DATA_W(64), .DEPTH(256), .WAIT_CYC(3)) dut1 (
      .clk(clk), .rst_n(rst_n), .bus(if1), .dbg_addr(dbg_addr), .dbg_data(dbg1));
   dmem_unit #(.DATA_W(64), .DEPTH(256), .WAIT_CYC(4)) dut2 (
      .clk(clk), .rst_n(rst_n), .bus(if2), .dbg_addr(dbg_addr), .dbg_data(dbg2));

   // Observe the selected unit.
   always_comb begin
      case (sel)
         1: begin
            req_ready = if1.req_ready; resp_valid = if1.resp_valid;
            valM = if1.valM; stat = if1.stat; dbg_data = dbg1;
         end
         2: begin
            req_ready = if2.req_ready; resp_valid = if2.resp_valid;
            valM = if2.valM; stat = if2.stat; dbg_data = dbg2;
         end
         default: begin
            req_ready = if0.req_ready; resp_valid = if0.resp_valid;
            valM = if0.valM; stat = if0.stat; dbg_data = dbg0;
         end
      endcase
   end

   function automatic int wait_of(input int k);
      return (k == 0) ? 0 : ((k == 1) ? 3 : 4);
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One complete transaction on unit k, checked against the reference model.
   task automatic txn(input int k, input logic [3:0] ic, input logic [63:0] a, input logic [63:0] e,
                      input logic [63:0] p, input int hold,
                      output logic [63:0] got_m, output logic [2:0] got_s);
      logic        mem, wr, legal, known;
      logic [63:0] addr, exp_m;
      logic [2:0]  exp_s;
      int          key, exp_lat, lat;
      mem   = ic inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
      wr    = ic inside {4'h4, 4'h8, 4'hA};
      addr  = (ic == 4'h9 || ic == 4'hB) ? a : e;
      legal = mem && (addr < 64'd256);
      key   = k * 1024 + int'(addr[7:0]);
      if (ic == 4'h0)          exp_s = 3'd2;
      else if (ic >= 4'hC)     exp_s = 3'd4;
      else if (mem && !legal)  exp_s = 3'd3;
      else                     exp_s = 3'd1;
      exp_m = 64'd0;
      known = 1'b1;
      if (legal && !wr) begin
         if (mdl.exists(key)) exp_m = mdl[key];
         else                 known = 1'b0;
      end
      if (legal && wr) mdl[key] = (ic == 4'h8) ? p : a;
      exp_lat = legal ? 1 + wait_of(k) : 1;

      @(negedge clk);
      sel = k; icode = ic; valA = a; valE = e; valP = p; req_valid = 1'b1; resp_ready = 1'b0;
      #1;
      check("req_ready_idle", {63'd0, req_ready}, 64'd1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      lat = 1;
      while (resp_valid !== 1'b1 && lat < 40) begin
         check("req_ready_busy", {63'd0, req_ready}, 64'd0);
         @(posedge clk);
         #1;
         lat++;
      end
      check("latency", 64'(lat), 64'(exp_lat));
      check("stat", {61'd0, stat}, {61'd0, exp_s});
      if (known) check("valM", valM, exp_m);
      got_m = valM;
      got_s = stat;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         check("hold_valid", {63'd0, resp_valid}, 64'd1);
         check("hold_valM", valM, got_m);
         check("hold_stat", {61'd0, stat}, {61'd0, got_s});
         check("hold_ready", {63'd0, req_ready}, 64'd0);
      end
      @(negedge clk);
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      resp_ready = 1'b0;
      check("resp_done", {63'd0, resp_valid}, 64'd0);
      check("ready_again", {63'd0, req_ready}, 64'd1);
   endtask

   initial begin
      logic [63:0] m, r;
      logic [2:0]  s;
      logic [3:0]  ic;
      rst_n = 1'b0; req_valid = 1'b0; resp_ready = 1'b0; sel = 0;
      icode = 4'h1; valA = '0; valE = '0; valP = '0; dbg_addr = '0;
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         sel = k;
         #1;
         check("rst_req_ready", {63'd0, req_ready}, 64'd1);
         check("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
         check("rst_stat", {61'd0, stat}, 64'd1);
         check("rst_valM", valM, 64'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;

      // Zero-wait unit: write, read back, debug port.
      txn(0, 4'h4, 64'hDEAD, 64'd5, 64'd0, 0, m, s);
      check("rmmovq_stat", {61'd0, s}, 64'd1);
      txn(0, 4'h5, 64'd0, 64'd5, 64'd0, 0, m, s);
      check("mrmovq_valM", m, 64'hDEAD);
      dbg_addr = 8'd5;
      #1;
      check("dbg5", dbg_data, 64'hDEAD);

      // Address range.
      txn(0, 4'h5, 64'd0, 64'h100, 64'd0, 0, m, s);
      check("adr_stat", {61'd0, s}, 64'd3);
      check("adr_valM", m, 64'd0);
      txn(0, 4'h4, 64'h1234, 64'h1_0000_0005, 64'd0, 0, m, s);
      check("adr_hi_stat", {61'd0, s}, 64'd3);
      #1;
      check("adr_hi_nowrite", dbg_data, 64'hDEAD);

      // Status codes.
      txn(0, 4'h0, 64'd0, 64'd5, 64'd0, 0, m, s);
      check("halt_stat", {61'd0, s}, 64'd2);
      txn(0, 4'hD, 64'd0, 64'd5, 64'd0, 0, m, s);
      check("ins_stat", {61'd0, s}, 64'd4);
      txn(0, 4'h6, 64'h77, 64'd5, 64'd0, 0, m, s);
      check("opq_stat", {61'd0, s}, 64'd1);
      check("opq_valM", m, 64'd0);
      #1;
      check("opq_nowrite", dbg_data, 64'hDEAD);

      // Back-pressure then ret.
      txn(0, 4'h8, 64'd0, 64'd3, 64'h40, 5, m, s);
      txn(0, 4'h9, 64'd3, 64'd0, 64'd0, 0, m, s);
      check("ret_valM", m, 64'h40);

      // Three wait cycles: push then pop.
      txn(1, 4'hA, 64'd7, 64'h10, 64'd0, 0, m, s);
      txn(1, 4'hB, 64'h10, 64'd0, 64'd0, 0, m, s);
      check("popq_valM", m, 64'd7);

      // Four wait cycles: reset aborts an uncommitted write.
      txn(2, 4'h4, 64'h11, 64'd9, 64'd0, 0, m, s);
      @(negedge clk);
      sel = 2; icode = 4'h4; valA = 64'h22; valE = 64'd9; req_valid = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_req_ready", {63'd0, req_ready}, 64'd1);
      check("abort_resp_valid", {63'd0, resp_valid}, 64'd0);
      check("abort_stat", {61'd0, stat}, 64'd1);
      check("abort_valM", valM, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(posedge clk);
      dbg_addr = 8'd9;
      #1;
      check("abort_nowrite", dbg_data, 64'h11);
      txn(2, 4'h5, 64'd0, 64'd9, 64'd0, 0, m, s);

      // Random traffic against the model.
      for (int k = 0; k < 3; k++) begin
         for (int n = 0; n < 30; n++) begin
            ic = 4'($urandom_range(0, 15));
            r  = ($urandom_range(0, 7) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 31));
            if (ic == 4'h9 || ic == 4'hB) txn(k, ic, r, {$urandom, $urandom}, {$urandom, $urandom},
                                              $urandom_range(0, 2), m, s);
            else txn(k, ic, {$urandom, $urandom}, r, {$urandom, $urandom},
                     $urandom_range(0, 2), m, s);
         end
      end

      // Debug port sweep over every written word.
      for (int k = 0; k < 3; k++) begin
         sel = k;
         for (int i = 0; i < 256; i++) begin
            if (mdl.exists(k * 1024 + i)) begin
               dbg_addr = 8'(i);
               #1;
               check("dbg_sweep", dbg_data, mdl[k * 1024 + i]);
            end
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
